// File: rtl/hvpi_defs.sv
// Shared constants for the HVPI interrupt controller.
// FSM encodings and channel-count limit.
package hvpi_defs;

  localparam int MAX_N = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

endpackage

// File: rtl/priority_encoder_n.sv
// N-input priority encoder, highest set index wins.
// noSig flags an all-zero input vector.
module priority_encoder_n
  import hvpi_defs::*;
#(
  parameter int N   = 8,
  parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]   vec,
  output logic [IDW-1:0] idx,
  output logic           noSig
);

  always_comb begin
    idx = '0;
    for (int k = 0; k < N; k++) begin
      if (vec[k]) idx = IDW'(k);
    end
  end

  assign noSig = ~|vec;

endmodule

// File: rtl/priority_interrupt_ctrl.sv
// Edge-detected, maskable interrupt controller with
// request/ack/eoi handshake to the vector logic.
module priority_interrupt_ctrl
  import hvpi_defs::*;
#(
  parameter int N = 8,
  localparam int IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   i,
  input  logic           enable,
  input  logic [N-1:0]   maskIn,
  input  logic           maskWe,
  input  logic           intAck,
  input  logic           eoi,
  output logic           intReq,
  output logic [IDW-1:0] intId,
  output logic           noSig
);

  state_t         state;
  state_t         state_nxt;
  logic [N-1:0]   prev;
  logic [N-1:0]   pending;
  logic [N-1:0]   mask;
  logic [N-1:0]   cand;
  logic [N-1:0]   clr;
  logic [IDW-1:0] win;
  logic           cand_none;
  logic           ack_take;
  logic           req_nxt;
  logic [IDW-1:0] id_nxt;

  assign cand = pending & ~mask;

  priority_encoder_n #(.N(N), .IDW(IDW)) u_enc (
    .vec   (cand),
    .idx   (win),
    .noSig (cand_none)
  );

  // enable low overrides a coincident ack
  assign ack_take = (state == ST_REQ) && enable && intAck;

  always_comb begin
    clr = '0;
    if (ack_take) clr[intId] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    req_nxt   = intReq;
    id_nxt    = intId;
    case (state)
      ST_IDLE: begin
        if (enable && !cand_none) begin
          state_nxt = ST_REQ;
          req_nxt   = 1'b1;
          id_nxt    = win;
        end
      end
      ST_REQ: begin
        if (!enable) begin
          state_nxt = ST_IDLE;
          req_nxt   = 1'b0;
        end else if (intAck) begin
          state_nxt = ST_SERVICE;
          req_nxt   = 1'b0;
        end else if (cand_none) begin
          state_nxt = ST_IDLE;
          req_nxt   = 1'b0;
        end else begin
          id_nxt = win;
        end
      end
      ST_SERVICE: begin
        if (eoi) state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
        req_nxt   = 1'b0;
      end
    endcase
  end

  // a new rise beats a same-cycle ack clear
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      prev    <= '1;
      pending <= '0;
      mask    <= '0;
      intReq  <= 1'b0;
      intId   <= '0;
      noSig   <= 1'b1;
    end else begin
      state   <= state_nxt;
      prev    <= i;
      pending <= (pending & ~clr) | (i & ~prev);
      if (maskWe) mask <= maskIn;
      intReq  <= req_nxt;
      intId   <= id_nxt;
      noSig   <= cand_none;
    end
  end

endmodule

// File: tb/tb_priority_interrupt_ctrl.sv
// Scoreboard bench: stimulus queues expected IDs, a
// monitor pops one per new request presentation.
module tb_priority_interrupt_ctrl;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] i;
  logic         enable;
  logic [N-1:0] maskIn;
  logic         maskWe;
  logic         intAck;
  logic         eoi;
  logic         intReq;
  logic [2:0]   intId;
  logic         noSig;

  int passed = 0;
  int total  = 0;
  int exp_q[$];

  priority_interrupt_ctrl #(.N(N)) dut (
    .clk    (clk),
    .reset  (reset),
    .i      (i),
    .enable (enable),
    .maskIn (maskIn),
    .maskWe (maskWe),
    .intAck (intAck),
    .eoi    (eoi),
    .intReq (intReq),
    .intId  (intId),
    .noSig  (noSig)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input string name);
    int c;
    c = 0;
    while (!intReq && c < 20) begin
      step(1);
      c++;
    end
    if (!intReq) chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic pulse(input logic [N-1:0] v);
    i = v;
    step(1);
    i = '0;
  endtask

  task automatic service(input string name);
    intAck = 1'b1;
    step(1);
    intAck = 1'b0;
    chk({name, "_ack_req"}, int'(intReq), 0);
    eoi = 1'b1;
    step(1);
    eoi = 1'b0;
  endtask

  // monitor: new presentation = rising intReq or ID change in REQ
  logic       last_req = 1'b0;
  logic [2:0] last_id  = '0;
  initial begin
    forever begin
      @(negedge clk);
      if (intReq && (!last_req || intId != last_id)) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_req", int'(intId), -1);
        end else begin
          chk("req_id", int'(intId), exp_q.pop_front());
        end
      end
      last_req = intReq;
      last_id  = intId;
    end
  end

  initial begin
    reset  = 1'b1;
    i      = 8'hFF;
    enable = 1'b1;
    maskIn = '0;
    maskWe = 1'b0;
    intAck = 1'b0;
    eoi    = 1'b0;
    step(2);
    chk("rst_intReq", int'(intReq), 0);
    chk("rst_intId", int'(intId), 0);
    chk("rst_noSig", int'(noSig), 1);
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step(1);
      chk("hold_intReq", int'(intReq), 0);
      chk("hold_noSig", int'(noSig), 1);
    end
    i = '0;
    step(2);

    // single source, latency 2
    exp_q.push_back(2);
    pulse(8'h04);
    chk("lat_e0_req", int'(intReq), 0);
    step(1);
    chk("lat_e1_req", int'(intReq), 1);
    chk("lat_e1_id", int'(intId), 2);
    intAck = 1'b1;
    step(1);
    intAck = 1'b0;
    chk("ack_req", int'(intReq), 0);
    chk("svc_id_held", int'(intId), 2);
    eoi = 1'b1;
    step(1);
    eoi = 1'b0;
    chk("eoi_noSig", int'(noSig), 1);
    step(2);
    chk("eoi_idle_req", int'(intReq), 0);

    // simultaneous: 6 before 1
    exp_q.push_back(6);
    exp_q.push_back(1);
    pulse(8'h42);
    wait_req("t3a");
    service("t3a");
    wait_req("t3b");
    service("t3b");

    // upgrade 3 -> 7 before ack, 3 remains pending
    exp_q.push_back(3);
    exp_q.push_back(7);
    exp_q.push_back(3);
    pulse(8'h08);
    wait_req("t4a");
    pulse(8'h80);
    step(1);
    chk("upgrade_id", int'(intId), 7);
    chk("upgrade_req", int'(intReq), 1);
    service("t4b");
    wait_req("t4c");
    service("t4c");

    // mask hides, unmask releases
    maskIn = 8'h10;
    maskWe = 1'b1;
    step(1);
    maskWe = 1'b0;
    pulse(8'h10);
    step(3);
    chk("mask_req", int'(intReq), 0);
    chk("mask_noSig", int'(noSig), 1);
    exp_q.push_back(4);
    maskIn = 8'h00;
    maskWe = 1'b1;
    step(1);
    maskWe = 1'b0;
    wait_req("t5");
    service("t5");

    // enable low beats ack, pending kept
    exp_q.push_back(5);
    pulse(8'h20);
    wait_req("t6a");
    enable = 1'b0;
    intAck = 1'b1;
    step(1);
    intAck = 1'b0;
    chk("dis_req", int'(intReq), 0);
    step(2);
    chk("dis_idle_req", int'(intReq), 0);
    chk("dis_noSig", int'(noSig), 0);
    exp_q.push_back(5);
    enable = 1'b1;
    wait_req("t6b");
    // rise on 5 coincides with ack clearing 5
    exp_q.push_back(5);
    intAck = 1'b1;
    i = 8'h20;
    step(1);
    intAck = 1'b0;
    i = '0;
    chk("setwin_ack_req", int'(intReq), 0);
    eoi = 1'b1;
    step(1);
    eoi = 1'b0;
    wait_req("t6c");
    service("t6c");
    step(3);
    chk("end_noSig", int'(noSig), 1);
    chk("end_req", int'(intReq), 0);

    // mid-operation reset
    exp_q.push_back(1);
    pulse(8'h02);
    wait_req("t7");
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("midrst_req", int'(intReq), 0);
    chk("midrst_id", int'(intId), 0);
    chk("midrst_noSig", int'(noSig), 1);
    step(4);
    chk("midrst_stays_idle", int'(intReq), 0);

    step(2);
    chk("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/priority_interrupt_ctrl.md
# priority_interrupt_ctrl

Parametrised, registered interrupt controller for the HVPI system. It replaces the fixed 4-input combinational priority encoder with N edge-detected request lines, a software-writable mask, per-channel pending latches and a request/acknowledge/end-of-interrupt handshake to the processor-side vector logic. Highest channel index has highest priority, matching the existing system convention.

## Interface
- `N`, 8: number of interrupt sources, legal range 2..32.
- `IDW`, derived localparam = ceil(log2(N)): width of the channel ID.
- `clk` input 1: single system clock. All state updates on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `i` input N: raw interrupt request lines. Synchronous to `clk`.
- `enable` input 1: global interrupt enable.
- `maskIn` input N: new mask value. Bit = 1 masks that channel.
- `maskWe` input 1: loads `maskIn` into the mask register.
- `intAck` input 1: processor accepts the presented request.
- `eoi` input 1: end of interrupt for the channel in service.
- `intReq` output 1: request to the processor, registered.
- `intId` output IDW: ID of the requested or in-service channel, registered.
- `noSig` output 1: registered; 1 when no unmasked channel is pending.

## Operation
- Edge detect:
  - `prev` holds last cycle's `i`.
  - A rise is `i & ~prev`.
  - A rise on channel k sets `pending[k]`.
  - Pending latches independently of mask, `enable` and FSM state.
- Mask:
  - On `maskWe`, mask <= `maskIn`.
  - The mask hides pending bits from arbitration. It never clears them.
- Candidate vector: `pending & ~mask`. The winner is the highest set index.
- FSM states: IDLE, REQ, SERVICE.
  - IDLE -> REQ when `enable` and the candidate vector is non-zero. `intId` <= winner, `intReq` <= 1.
  - REQ, `enable` = 0: go to IDLE, `intReq` <= 0. Pending is kept.
  - REQ, `intAck` = 1: clear `pending[intId]`, go to SERVICE, `intReq` <= 0. `intId` is held.
  - REQ, otherwise: `intId` <= current winner. A higher-priority arrival upgrades the ID before ack. If the candidate vector empties (e.g. masked), go to IDLE and `intReq` <= 0.
  - SERVICE, `eoi` = 1: go to IDLE.
  - SERVICE: `enable` and the mask have no effect. No nesting.
- Ignored inputs:
  - `intAck` outside REQ.
  - `eoi` outside SERVICE.
- Simultaneous events:
  - A rise on channel k in the same cycle `intAck` clears `pending[k]`: set wins, and `pending[k]` stays 1.
  - `enable` = 0 together with `intAck` in REQ: `enable` wins, and the ack is ignored.
- `noSig` <= ~|(candidate vector), updated every cycle in every state.

## Timing
- Reset values:
  - `pending` = 0, mask = 0, state IDLE.
  - `prev` = all ones, so lines held high through reset raise no interrupt.
  - `intReq` = 0, `intId` = 0, `noSig` = 1.
- Reset asserted mid-operation, in any state, returns everything to the reset values at the next edge.
- Latency from a rise on `i` to `intReq`:
  - The rise sampled at edge E0 makes `pending` = 1 after E0.
  - `intReq` and `intId` are valid after E1, i.e. 2 cycles.
- `intAck` sampled at edge Ea: `intReq` = 0 and state SERVICE after Ea. The pending bit is clear after Ea.
- `eoi` at edge Ee: IDLE after Ee. The next request can appear after Ee+1 at the earliest.
- `intId` changes only at clock edges. It is stable in SERVICE.

## Structure
- Shared constants file `hvpi_defs`:
  - FSM state encodings `ST_IDLE` = 2'd0, `ST_REQ` = 2'd1, `ST_SERVICE` = 2'd2.
  - Maximum channel count (32).
- Sub-module `priority_encoder_n`: combinational, parameter N. Inputs: vector. Outputs: IDW-bit index and `noSig`.
- Pending/mask registers and the FSM stay in the top module.

## Test plan
- Reset with `i` = 8'hFF held high, then hold for 10 cycles -> `intReq` stays 0, `noSig` = 1.
- N=8, pulse `i[2]` -> `intReq` = 1 and `intId` = 2 two cycles later; ack -> `intReq` = 0; `eoi` -> IDLE; `noSig` = 1.
- Pulse `i[1]` and `i[6]` in the same cycle -> ID 6 presented first; ack and `eoi` -> ID 1 presented next.
- Pulse `i[3]`, and while in REQ pulse `i[7]` -> `intId` upgrades from 3 to 7 before ack; after ack on 7, `pending[3]` is still 1.
- Write mask = 8'h10, then pulse `i[4]` -> no request, `noSig` = 1; write mask = 0 -> request with ID 4 follows.
- In REQ: `enable` = 0 with `intAck` = 1 -> ack ignored, IDLE, `pending` kept. Then `enable` = 1 -> re-request. Then a rise on channel k in the same cycle as the ack clearing k -> `pending[k]` = 1.
